// File: rtl/triple_accum.sv
// triple_accum: sums each group of NUM_SAMPLES accepted 6-bit triple results
// into one frame sum and presents it on a valid/ready output until taken.
// Two states: COLLECT accumulates samples, HOLD presents the finished sum.
module triple_accum #(
  parameter int DATA_W      = 6,
  parameter int NUM_SAMPLES = 4,
  localparam int SUM_W      = DATA_W + $clog2(NUM_SAMPLES),
  localparam int CNT_W      = $clog2(NUM_SAMPLES) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count
);

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic               valid_q, valid_d;

  logic               in_accept;
  logic               out_accept;
  logic               last_sample;
  logic [SUM_W-1:0]   sample_ext;
  logic [SUM_W-1:0]   acc_plus;

  // Handshake decode; in_ready comes only from state so it never depends on out_ready.
  assign in_accept   = in_valid & in_ready;
  assign out_accept  = valid_q & out_ready;
  assign last_sample = (cnt_q == LAST_CNT);
  assign sample_ext  = {{(SUM_W - DATA_W){1'b0}}, in_data};
  assign acc_plus    = acc_q + sample_ext;

  // State and datapath registers; reset discards any partial or pending frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_COLLECT;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic: leave COLLECT on the last sample, leave HOLD when the sink takes the sum.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_COLLECT: if (in_accept && last_sample) state_d = ST_HOLD;
      ST_HOLD:    if (out_accept)               state_d = ST_COLLECT;
      default:                                  state_d = ST_COLLECT;
    endcase
  end

  // Datapath next values: accumulate accepted samples, publish and clear on frame end.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_COLLECT: begin
        if (in_accept) begin
          if (last_sample) begin
            sum_d   = acc_plus;
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            acc_d = acc_plus;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        // out_sum is deliberately kept after hand-off; only valid drops.
        if (out_accept) valid_d = 1'b0;
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  // Output decode: ready only while collecting, outputs straight from registers.
  always_comb begin
    in_ready  = (state_q == ST_COLLECT);
    out_valid = valid_q;
    out_sum   = sum_q;
    out_count = cnt_q;
  end

endmodule

// File: tb/tb_triple_accum.sv
// tb_triple_accum: table-driven directed vectors, hand-written reset
// sequences and a randomized run against a frame-level reference model.
module tb_triple_accum;
  localparam int DATA_W      = 6;
  localparam int NUM_SAMPLES = 4;
  localparam int SUM_W       = 8;
  localparam int CNT_W       = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  triple_accum #(.DATA_W(DATA_W), .NUM_SAMPLES(NUM_SAMPLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
  );

  typedef struct {
    logic              v;
    logic [DATA_W-1:0] d;
    logic              r;
    logic              e_rdy;
    logic              e_ov;
    logic [SUM_W-1:0]  e_sum;
    logic [CNT_W-1:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input int d, input logic r, input logic e_rdy,
                     input logic e_ov, input int e_sum, input int e_cnt);
    vec_t t;
    t.v = v; t.d = DATA_W'(d); t.r = r;
    t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_sum = SUM_W'(e_sum); t.e_cnt = CNT_W'(e_cnt);
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_rdy, input logic e_ov,
                          input int e_sum, input int e_cnt);
    chk({tag, ".in_ready"},  32'(in_ready),  32'(e_rdy));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
    chk({tag, ".out_sum"},   32'(out_sum),   32'(e_sum));
    chk({tag, ".out_count"}, 32'(out_count), 32'(e_cnt));
  endtask

  // Apply inputs for one cycle, then move to 1 time unit after the rising edge.
  task automatic drive(input logic v, input int d, input logic r);
    in_valid  = v;
    in_data   = DATA_W'(d);
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Frame-level model: a list of accepted samples, summed when it reaches NUM_SAMPLES.
  int  m_q[$];
  bit  m_hold;
  int  m_sum;

  task automatic model_step(input logic v, input int d, input logic r);
    int s;
    if (v && !m_hold) begin
      m_q.push_back(d);
      if (m_q.size() == NUM_SAMPLES) begin
        s = 0;
        foreach (m_q[k]) s += m_q[k];
        m_sum  = s;
        m_hold = 1'b1;
        m_q.delete();
      end
    end else if (m_hold && r) begin
      m_hold = 1'b0;
    end
  endtask

  initial begin
    int prev_pulse;
    int pulses;
    int a;
    logic v, r;
    int d;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    chk_outs("reset", 1'b1, 1'b0, 0, 0);

    // Test 1: 0,3,9,15 -> 27
    add(1, 0, 1,  1, 0, 0, 1);
    add(1, 3, 1,  1, 0, 0, 2);
    add(1, 9, 1,  1, 0, 0, 3);
    add(1, 15, 1, 0, 1, 27, 0);
    add(0, 63, 1, 1, 0, 27, 0);
    // Test 2: 45 x4 -> 180, then 0 x4 -> 0
    add(1, 45, 1, 1, 0, 27, 1);
    add(1, 45, 1, 1, 0, 27, 2);
    add(1, 45, 1, 1, 0, 27, 3);
    add(1, 45, 1, 0, 1, 180, 0);
    add(0, 0, 1,  1, 0, 180, 0);
    add(1, 0, 1,  1, 0, 180, 1);
    add(1, 0, 1,  1, 0, 180, 2);
    add(1, 0, 1,  1, 0, 180, 3);
    add(1, 0, 1,  0, 1, 0, 0);
    add(0, 0, 1,  1, 0, 0, 0);
    // Test 3: 3 x4 held by back-pressure while 30 is offered, then 1 x4 -> 4
    add(1, 3, 0,  1, 0, 0, 1);
    add(1, 3, 0,  1, 0, 0, 2);
    add(1, 3, 0,  1, 0, 0, 3);
    add(1, 3, 0,  0, 1, 12, 0);
    for (int i = 0; i < 5; i++) add(1, 30, 0, 0, 1, 12, 0);
    add(0, 30, 1, 1, 0, 12, 0);
    add(1, 1, 1,  1, 0, 12, 1);
    add(1, 1, 1,  1, 0, 12, 2);
    add(1, 1, 1,  1, 0, 12, 3);
    add(1, 1, 1,  0, 1, 4, 0);
    add(0, 0, 1,  1, 0, 4, 0);
    // Test 4: 15,30,6,9 with valid pattern 1-0-0-1-0-1-1 and garbage data in gaps
    add(1, 15, 1, 1, 0, 4, 1);
    add(0, 55, 1, 1, 0, 4, 1);
    add(0, 21, 1, 1, 0, 4, 1);
    add(1, 30, 1, 1, 0, 4, 2);
    add(0, 63, 1, 1, 0, 4, 2);
    add(1, 6, 1,  1, 0, 4, 3);
    add(1, 9, 1,  0, 1, 60, 0);
    add(0, 0, 1,  1, 0, 60, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].v, int'(tbl[i].d), tbl[i].r);
      chk_outs($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_ov,
               int'(tbl[i].e_sum), int'(tbl[i].e_cnt));
    end

    // Test 5a: reset in the middle of a partial frame
    drive(1, 30, 1);
    drive(1, 30, 1);
    chk("mid_frame.count", 32'(out_count), 32'd2);
    #2 rst = 1'b1;
    #1 chk_outs("rst_mid_frame", 1'b1, 1'b0, 0, 0);
    #2 rst = 1'b0;

    // Test 5b: reset while a finished frame is held
    for (int i = 0; i < NUM_SAMPLES; i++) drive(1, 10, 0);
    chk("hold.valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1 chk_outs("rst_mid_hold", 1'b1, 1'b0, 0, 0);
    #2 rst = 1'b0;

    drive(0, 0, 1);
    chk_outs("after_rst", 1'b1, 1'b0, 0, 0);
    drive(1, 3, 1);
    drive(1, 6, 1);
    drive(1, 9, 1);
    drive(1, 12, 1);
    chk_outs("rst_refeed", 1'b0, 1'b1, 30, 0);
    drive(0, 0, 1);

    // Test 6: valid and ready tied high, frames of 3*a
    m_q.delete(); m_hold = 1'b0; m_sum = 30;
    prev_pulse = -1; pulses = 0;
    for (int cyc = 0; cyc < 5 * 4; cyc++) begin
      a = $urandom_range(0, 15);
      drive(1, 3 * a, 1);
      model_step(1'b1, 3 * a, 1'b1);
      if (m_hold) chk($sformatf("stream.sum c%0d", cyc), 32'(out_sum), 32'(m_sum));
      chk($sformatf("stream.valid c%0d", cyc), 32'(out_valid), 32'(m_hold));
      if (out_valid) begin
        pulses++;
        if (prev_pulse >= 0) chk("stream.period", 32'(cyc - prev_pulse), 32'd5);
        prev_pulse = cyc;
      end
    end
    chk("stream.pulses", 32'(pulses), 32'd4);

    // Random valid/ready against the model
    for (int cyc = 0; cyc < 300; cyc++) begin
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 3) != 0);
      d = v ? 3 * $urandom_range(0, 15) : $urandom_range(0, 63);
      drive(v, d, r);
      model_step(v, d, r);
      chk($sformatf("rand.in_ready c%0d", cyc), 32'(in_ready), 32'(!m_hold));
      chk($sformatf("rand.valid c%0d", cyc), 32'(out_valid), 32'(m_hold));
      chk($sformatf("rand.sum c%0d", cyc), 32'(out_sum), 32'(m_sum));
      chk($sformatf("rand.count c%0d", cyc), 32'(out_count), 32'(m_q.size()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
